// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//
// Boot-time instruction-memory loader. After an accepted start it receives
// a stream of program bytes, packs them little-endian into 32-bit words,
// writes each word to consecutive instruction-memory addresses starting at 0,
// and then checks one trailing checksum byte against the XOR of all data
// bytes. The fetch stage is only allowed to run (fetch_en) once a load has
// finished with a matching checksum.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : one-cycle load request, honoured only in IDLE or DONE
//   word_count  : words to load, sampled with an accepted start (0 = 2^ADDR_W)
//   byte_valid  : source presents byte_data
//   byte_data   : serial program byte
//   byte_ready  : loader accepts a byte this cycle (RECV and CHECK only)
//   IM_Wr_En    : one-cycle instruction-memory write strobe
//   IM_Wr_Addr  : word address of the write
//   IM_Wr_Data  : assembled instruction word
//   busy        : a load is in progress
//   done        : the last load has completed (level)
//   err         : checksum mismatch on the last load
//   fetch_en    : fetch stage may drive PC_Write / IR_Write
// -----------------------------------------------------------------------------
module im_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              IM_Wr_En,
    output logic [ADDR_W-1:0] IM_Wr_Addr,
    output logic [31:0]       IM_Wr_Data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              fetch_en
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // A count of zero stands for a full memory image.
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr;        // address of the word being assembled
    logic [ADDR_W:0]   remaining;   // words still to be written, incl. current
    logic [1:0]        byte_idx;    // position of the next byte within the word
    logic [23:0]       word_low;    // first three bytes of the current word
    logic [7:0]        csum;        // running XOR of all data bytes
    logic              err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    logic              xfer;
    logic              start_ok;

    // byte_ready depends only on state, so a transfer needs no extra gating.
    assign xfer     = byte_valid && byte_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        IM_Wr_En   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fetch_en   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = RECV;
                end
            end

            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end

            WRITE: begin
                IM_Wr_En = 1'b1;
                busy     = 1'b1;
                // remaining still includes the word being written here.
                if (remaining == ONE_COUNT) begin
                    state_next = CHECK;
                end else begin
                    state_next = RECV;
                end
            end

            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done     = 1'b1;
                fetch_en = !err_q;
                if (start_ok) begin
                    state_next = RECV;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load bookkeeping: address, word count, byte index, checksum, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            byte_idx  <= 2'd0;
            word_low  <= 24'd0;
            csum      <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                addr      <= '0;
                remaining <= (word_count == '0) ? FULL_COUNT : word_count;
                byte_idx  <= 2'd0;
                csum      <= 8'd0;
                err_q     <= 1'b0;
            end

            if ((state == RECV) && xfer) begin
                csum     <= csum ^ byte_data;
                byte_idx <= byte_idx + 2'd1;  // wraps to 0 after the 4th byte
                case (byte_idx)
                    2'd0:    word_low[7:0]   <= byte_data;
                    2'd1:    word_low[15:8]  <= byte_data;
                    2'd2:    word_low[23:16] <= byte_data;
                    default: ;
                endcase
            end

            if (state == WRITE) begin
                addr      <= addr + 1'b1;     // wraps modulo 2^ADDR_W
                remaining <= remaining - ONE_COUNT;
            end

            if ((state == CHECK) && xfer) begin
                err_q <= (byte_data != csum);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write port registers. They load only when the 4th byte arrives, so the
    // memory sees a stable address/data everywhere outside the write strobe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else if ((state == RECV) && xfer && (byte_idx == 2'd3)) begin
            wr_addr_q <= addr;
            wr_data_q <= {byte_data, word_low};
        end
    end

    assign IM_Wr_Addr = wr_addr_q;
    assign IM_Wr_Data = wr_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//
// Self-checking bench for im_loader. Each load is described by a byte list
// (data bytes followed by the checksum byte); the expected writes, error flag
// and latency are derived from that list directly.
// -----------------------------------------------------------------------------
module tb_im_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              IM_Wr_En;
    logic [ADDR_W-1:0] IM_Wr_Addr;
    logic [31:0]       IM_Wr_Data;
    logic              busy;
    logic              done;
    logic              err;
    logic              fetch_en;

    im_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .IM_Wr_En   (IM_Wr_En),
        .IM_Wr_Addr (IM_Wr_Addr),
        .IM_Wr_Data (IM_Wr_Data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fetch_en   (fetch_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed writes and write-port stability violations.
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0]       prev_data = '0;
    int                stab_bad  = 0;

    always @(negedge clk) begin
        if (rst_n && IM_Wr_En) begin
            got_addr.push_back(IM_Wr_Addr);
            got_data.push_back(IM_Wr_Data);
        end
        if (rst_n && !IM_Wr_En && ((IM_Wr_Addr != prev_addr) || (IM_Wr_Data != prev_data)))
            stab_bad++;
        prev_addr = IM_Wr_Addr;
        prev_data = IM_Wr_Data;
    end

    logic [7:0] stim[$];

    task automatic make_stim(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        stim.delete();
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        stim.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
        bit acc;
        int guard;
        if (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            guard++;
        end
        ok = acc;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {byte_ready, IM_Wr_En, IM_Wr_Addr, IM_Wr_Data, busy, done, err, fetch_en}, '0);
    endtask

    // Run one load of the bytes in stim and compare against the model.
    task automatic run_load(input int wc, input bit gaps, input bit poke, input string tag);
        int         n;
        int         c0;
        int         guard;
        bit         ok;
        logic [7:0] x;
        bit         exp_err;
        logic [31:0] exp_word;

        n = (wc == 0) ? DEPTH : wc;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= stim[i];
        exp_err = (stim[4 * n] != x);

        got_addr.delete();
        got_data.delete();
        stab_bad = 0;

        @(posedge clk); #1;
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(wc);
        c0         = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        word_count = (ADDR_W + 1)'($urandom);
        check_eq({tag, "_busy_after_start"}, busy, 1'b1);
        check_eq({tag, "_done_clr"}, {done, err, fetch_en}, 3'b000);

        for (int k = 0; k <= 4 * n; k++) begin
            if (poke && k == 5) begin
                start      = 1'b1;
                word_count = (ADDR_W + 1)'(3);
            end
            send_byte(stim[k], gaps, ok);
            start = 1'b0;
            if (!ok) begin
                check_eq({tag, "_byte_accept_timeout"}, 0, 1);
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;

        guard = 0;
        @(negedge clk);
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_done"}, done, 1'b1);
        if (!gaps) check_eq({tag, "_latency"}, cyc - c0, 5 * n + 2);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_fetch_en"}, fetch_en, !exp_err);
        check_eq({tag, "_busy_done"}, {busy, byte_ready}, 2'b00);

        check_eq({tag, "_nwrites"}, got_addr.size(), n);
        if (got_addr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                exp_word = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
                check_eq({tag, "_addr"}, got_addr[i], (i % DEPTH));
                check_eq({tag, "_data"}, got_data[i], exp_word);
            end
        end
        check_eq({tag, "_wr_stable"}, stab_bad, 0);

        // done is a level: it stays up while idle.
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_hold"}, {done, err, fetch_en}, {1'b1, exp_err, !exp_err});
    endtask

    initial begin
        bit ok;
        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        #3;
        check_all_zero("reset_async");
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");

        // Single word, good checksum.
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load(1, 1'b0, 1'b0, "one_word");

        // Single word, bad checksum.
        stim = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
        run_load(1, 1'b0, 1'b0, "bad_csum");

        // Full wrapped count.
        make_stim(DEPTH, 1'b0);
        run_load(0, 1'b0, 1'b0, "wrap64");

        // Two words gap-free, then the same bytes with gaps.
        make_stim(2, 1'b0);
        run_load(2, 1'b0, 1'b0, "two_nogap");
        run_load(2, 1'b1, 1'b0, "two_gap");

        // Start pulsed during a load.
        make_stim(3, 1'b0);
        run_load(3, 1'b0, 1'b1, "start_busy");

        // Reset in the middle of word 0 after a good load (fetch_en was 1).
        make_stim(2, 1'b0);
        got_addr.delete();
        got_data.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(2);
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(stim[0], 1'b0, ok);
        send_byte(stim[1], 1'b0, ok);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("midload_no_write", got_addr.size(), 0);
        check_all_zero("midload_after_release");
        make_stim(2, 1'b0);
        run_load(2, 1'b0, 1'b0, "reload");

        // Randomized loads.
        for (int it = 0; it < 10; it++) begin
            int  wc;
            bit  gp;
            bit  bd;
            bit  pk;
            wc = $urandom_range(1, 6);
            gp = 1'($urandom);
            bd = ($urandom_range(0, 3) == 0);
            pk = (wc >= 2) && 1'($urandom);
            make_stim(wc, bd);
            run_load(wc, gp, pk, $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface -- parameters
REQ-001 SHALL provide parameter ADDR_W, default 6, the instruction-memory word-address width (64 words).

Interface -- ports
REQ-002 SHALL provide clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL provide rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide start, input, 1: single-cycle request to begin a load.
REQ-005 SHALL provide word_count, input, ADDR_W+1: number of words to load, sampled on an accepted start.
REQ-006 SHALL provide byte_valid, input, 1: the source presents byte_data.
REQ-007 SHALL provide byte_data, input, 8: serial program byte.
REQ-008 SHALL provide byte_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 SHALL provide IM_Wr_En, output, 1: instruction-memory write strobe.
REQ-010 SHALL provide IM_Wr_Addr, output, ADDR_W: word address of the write.
REQ-011 SHALL provide IM_Wr_Data, output, 32: assembled instruction word.
REQ-012 SHALL provide busy, output, 1: high while a load is in progress.
REQ-013 SHALL provide done, output, 1: the load completed; level signal.
REQ-014 SHALL provide err, output, 1: checksum mismatch on the last load.
REQ-015 SHALL provide fetch_en, output, 1: permission for the fetch stage to drive PC_Write and IR_Write.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE, CHECK and DONE.
REQ-017 SHALL define a byte transfer as byte_valid && byte_ready at a rising edge; there is no other acceptance path.
REQ-018 SHALL drive byte_ready high only in RECV and CHECK; it is combinational from state and does not depend on byte_valid.
REQ-019 SHALL, in IDLE or DONE, act on start as follows:
  - latch word_count (value 0 means 2^ADDR_W words);
  - clear the address to 0, the byte index, the checksum, done and err;
  - enter RECV on the next cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL, in RECV, pack bytes little-endian: the 1st accepted byte goes to bits 7:0 and the 4th to bits 31:24; each byte is XORed into an 8-bit checksum.
REQ-022 SHALL move from RECV to WRITE on the cycle after the 4th byte is accepted.
REQ-023 SHALL, in WRITE, hold IM_Wr_En=1 for exactly one cycle, with IM_Wr_Addr set to the current address and IM_Wr_Data set to the assembled word.
REQ-024 SHALL, after WRITE, increment the address (wrapping modulo 2^ADDR_W) and decrement the remaining count, then enter CHECK if the count is 0, else RECV.
REQ-025 SHALL, in CHECK, compare the next accepted byte with the running checksum, set err=1 on mismatch, then enter DONE.
REQ-026 SHALL, in DONE, hold done=1 and set fetch_en = !err until the next accepted start.
REQ-027 SHALL drive busy=1 in RECV, WRITE and CHECK, and busy=0 in IDLE and DONE.
REQ-028 SHALL not stall or time out on a gap in byte_valid; the state and byte index hold until the next transfer.
REQ-029 SHALL hold IM_Wr_Addr and IM_Wr_Data stable whenever IM_Wr_En=0.
REQ-030 SHALL make the minimum load latency 5*N+2 cycles from start to done=1 for N words with byte_valid held high.

Reset
REQ-031 SHALL, on rst_n low, immediately and asynchronously set:
  - state IDLE;
  - byte_ready=0, IM_Wr_En=0, IM_Wr_Addr=0, IM_Wr_Data=0;
  - busy=0, done=0, err=0, fetch_en=0;
  - byte index 0 and checksum 0.
REQ-032 SHALL, on reset mid-load, discard any partial word with no write; a new start is required after rst_n rises.
REQ-033 SHALL keep fetch_en=0 from reset until a load finishes without error.

Verification
REQ-034 SHALL cover a single-word load:
  - stimulus: word_count=1, bytes 13,00,00,00, then checksum 13;
  - response: one IM_Wr_En pulse at addr 0 with data 0x00000013, then done=1, err=0, fetch_en=1.
REQ-035 SHALL cover a bad checksum:
  - stimulus: the same 1-word load with checksum byte FF;
  - response: the write still occurs, then done=1, err=1, fetch_en=0.
REQ-036 SHALL cover a wrapped count:
  - stimulus: word_count=0 with byte_valid always high;
  - response: 64 writes at addr 0..63 in order, and done at cycle 5*64+2.
REQ-037 SHALL cover source gaps:
  - stimulus: byte_valid toggling 1/0 during a 2-word load;
  - response: data and addresses match the gap-free run, with no extra writes.
REQ-038 SHALL cover reset mid-load:
  - stimulus: rst_n low after 2 bytes of word 0;
  - response: IM_Wr_En never pulses and all outputs return to 0; a subsequent start reloads from addr 0.
REQ-039 SHALL cover start while busy:
  - stimulus: start pulsed mid-load;
  - response: no effect on the count, address or state.
